load_store_unit: RTL and testbench
==================================

Name: load_store_unit

Overview:
- MEM-stage access controller sitting directly upstream of the word-addressed data memory; it drives that memory's Wen/Ren/Adress/DataW and consumes its DataR.
- Converts byte-addressed CPU load/store requests (byte, halfword, word; signed or unsigned loads) into single-word memory cycles.
- Sub-word stores are done as read-modify-write.
- Provides a busy/done handshake so the pipeline can stall.

Parameters:
- MEM_WORDS, 256, number of 32-bit words in the data memory; word index range 0..MEM_WORDS-1.

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  asynchronous, active-high reset
- req  input  1  request strobe, sampled only in IDLE
- we  input  1  1 = store, 0 = load
- size  input  2  00 byte, 01 halfword, 10 word, 11 illegal
- sign_ext  input  1  loads only: 1 = sign-extend, 0 = zero-extend
- addr  input  32  byte address
- wdata  input  32  store data, right-aligned
- busy  output  1  high from the cycle after req is accepted until done
- done  output  1  one-cycle completion pulse
- err  output  1  valid with done: misaligned, illegal size or out of range
- rdata  output  32  load result, valid with done, held until the next done
- mem_wen  output  1  to memory Wen
- mem_ren  output  1  to memory Ren
- mem_addr  output  32  word index (addr[31:2]), zero-extended
- mem_dataw  output  32  to memory DataW
- mem_datar  input  32  from memory DataR; combinational read

Behaviour:
- Reset (asynchronous, immediate) forces the FSM to IDLE and clears all outputs, including captured request registers, to 0.
- In IDLE, when req=1, capture we, size, sign_ext, addr and wdata, and set busy on the next edge. Input changes after capture are ignored.
- States: IDLE, READ, WRITE, DONE.
- Error check at acceptance. err is set when any of these hold:
  - size=11
  - halfword with addr[0]=1
  - word with addr[1:0]!=0
  - addr[31:2] >= MEM_WORDS
- On error: go IDLE->DONE. Neither mem_wen nor mem_ren is asserted, rdata is unchanged, and done=1 with err=1.
- Load: IDLE -> READ -> DONE.
  - In READ, mem_ren=1 and mem_addr is stable.
  - At the end of READ, latch mem_datar, then select the lane by addr[1:0] (little-endian: offset 0 = bits 7:0).
  - Extend per sign_ext into rdata. Word loads ignore sign_ext.
  - done is asserted 2 cycles after the req cycle.
- Word store: IDLE -> WRITE -> DONE.
  - In WRITE, mem_wen=1 for exactly one cycle, with mem_addr and mem_dataw stable for the whole cycle.
- Byte/halfword store: IDLE -> READ -> WRITE -> DONE.
  - In WRITE, mem_dataw is the latched old word with only the addressed lane(s) replaced by wdata[7:0] or wdata[15:0].
  - done is asserted 3 cycles after the req cycle.
- DONE: done=1 and busy=0 for one cycle, then IDLE. A req seen during DONE is not accepted; it must be held into IDLE.
- mem_wen and mem_ren are never high together. Both are 0 in IDLE and DONE.
- mem_addr and mem_dataw are registered outputs and hold their last value when idle.
- req while busy is ignored; there is no queueing.
- Reset during READ or WRITE aborts the access. mem_wen drops asynchronously with rst and no partial merge is written.

Optional Feature:
- Macro: LSU_WORD_CACHE_EN.
- When defined, a one-entry register holds the last word read or written plus its index and a valid bit; valid is cleared on reset.
- A load hitting a valid entry skips READ (IDLE->DONE), giving latency 1 with no mem_ren.
- A sub-word store hit also skips READ.
- Every store updates the entry with the word written; every READ fills it.
- When undefined, there are no extra registers and latencies are exactly as above.

Test Plan:
- Memory word 16 = 32'd123; load word addr 0x40 -> mem_ren high 1 cycle with mem_addr=16, done 2 cycles after req, rdata=0x0000007B, err=0.
- Word 16 = 0x0000007B; store byte wdata=0x000000AA at addr 0x41 -> READ then WRITE, mem_dataw=0x0000AA7B, single mem_wen pulse, done 3 cycles after req; then load byte signed at addr 0x41 -> rdata=0xFFFFFFAA, and unsigned -> 0x000000AA.
- Halfword store at addr 0x43, and a word load at addr 0x400 (index 256) -> done 1 cycle after req with err=1, no mem_wen/mem_ren pulses, rdata unchanged.
- Sub-word store issued, rst pulsed during READ -> busy=0 and done=0 immediately, mem_wen never asserted, word 16 unchanged.
- Second req asserted while busy -> ignored: exactly one done pulse, and mem_addr reflects only the first request.
- With LSU_WORD_CACHE_EN: two back-to-back loads of addr 0x40 -> second completes 1 cycle after req with no mem_ren; a store word 0x12345678 to 0x40 followed by a load -> rdata=0x12345678.

Source files
------------

// File: rtl/load_store_unit_if.sv
// Bus bundle between the pipeline/memory side and the load/store unit.
// Carries the CPU request handshake and the word-addressed data-memory port.
// The slave modport is the load/store unit; the master modport is whatever
// drives requests and provides the memory read data.
interface load_store_unit_if;
   // CPU request side
   logic        req;
   logic        we;
   logic [1:0]  size;
   logic        sign_ext;
   logic [31:0] addr;
   logic [31:0] wdata;
   logic        busy;
   logic        done;
   logic        err;
   logic [31:0] rdata;
   // Data memory side
   logic        mem_wen;
   logic        mem_ren;
   logic [31:0] mem_addr;
   logic [31:0] mem_dataw;
   logic [31:0] mem_datar;

   modport master (
      output req, we, size, sign_ext, addr, wdata, mem_datar,
      input  busy, done, err, rdata, mem_wen, mem_ren, mem_addr, mem_dataw
   );

   modport slave (
      input  req, we, size, sign_ext, addr, wdata, mem_datar,
      output busy, done, err, rdata, mem_wen, mem_ren, mem_addr, mem_dataw
   );
endinterface

// File: rtl/load_store_unit.sv
// MEM-stage load/store unit in front of a word-addressed data memory.
// Turns byte-addressed byte/halfword/word requests into single-word memory
// cycles; sub-word stores are read-modify-write. Optional macro
// LSU_WORD_CACHE_EN adds a one-entry word buffer that lets loads and sub-word
// stores to the most recently touched word skip the memory read.
module load_store_unit #(
   parameter int MEM_WORDS = 256
) (
   input logic              clk,
   input logic              rst,
   load_store_unit_if.slave bus
);

   localparam logic [1:0]  SZ_BYTE     = 2'b00;
   localparam logic [1:0]  SZ_HALF     = 2'b01;
   localparam logic [1:0]  SZ_WORD     = 2'b10;
   localparam logic [1:0]  SZ_ILLEGAL  = 2'b11;
   localparam logic [31:0] MEM_WORDS_W = 32'(MEM_WORDS);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      READ  = 2'd1,
      WRITE = 2'd2,
      DONE  = 2'd3
   } state_t;

   state_t      state, state_next;

   // Captured request; only the low 16 bits of store data matter for merges
   logic        we_reg;
   logic [1:0]  size_reg;
   logic        sign_reg;
   logic [1:0]  off_reg;
   logic [15:0] wdata_reg;
   logic        err_reg;

   logic [31:0] rdata_reg;
   logic [31:0] mem_addr_reg;
   logic [31:0] mem_dataw_reg;

   logic        accept;
   logic        req_err;
   logic        hit;
   logic [31:0] hit_word;

   // Pick the addressed lane out of a memory word and extend it to 32 bits.
   function automatic logic [31:0] lane_extract(input logic [31:0] word,
                                                input logic [1:0]  off,
                                                input logic [1:0]  size,
                                                input logic        sx);
      logic [31:0] shifted;
      shifted = word >> {off, 3'b000};
      case (size)
         SZ_WORD: return word;
         SZ_HALF: return {{16{sx & shifted[15]}}, shifted[15:0]};
         default: return {{24{sx & shifted[7]}}, shifted[7:0]};
      endcase
   endfunction

   // Replace only the addressed byte/halfword lane of the old word.
   function automatic logic [31:0] lane_merge(input logic [31:0] old,
                                              input logic [15:0] wd,
                                              input logic [1:0]  off,
                                              input logic [1:0]  size);
      logic [31:0] mask;
      logic [31:0] data;
      mask = (size == SZ_HALF) ? 32'h0000_FFFF : 32'h0000_00FF;
      mask = mask << {off, 3'b000};
      data = {16'h0000, wd} << {off, 3'b000};
      return (old & ~mask) | (data & mask);
   endfunction

   assign accept = (state == IDLE) && bus.req;

   // Reject illegal size, misalignment and out-of-range word indices up front
   always_comb begin
      req_err = 1'b0;
      case (bus.size)
         SZ_ILLEGAL: req_err = 1'b1;
         SZ_HALF:    req_err = bus.addr[0];
         SZ_WORD:    req_err = (bus.addr[1:0] != 2'b00);
         default:    req_err = 1'b0;
      endcase
      if ({2'b00, bus.addr[31:2]} >= MEM_WORDS_W) begin
         req_err = 1'b1;
      end
   end

`ifdef LSU_WORD_CACHE_EN
   logic        cache_valid;
   logic [29:0] cache_idx;
   logic [31:0] cache_data;

   assign hit      = cache_valid && (cache_idx == bus.addr[31:2]);
   assign hit_word = cache_data;

   // Keep the buffered word coherent with every word read or written
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cache_valid <= 1'b0;
         cache_idx   <= '0;
         cache_data  <= '0;
      end else if (accept && !req_err && bus.we) begin
         if (bus.size == SZ_WORD) begin
            cache_valid <= 1'b1;
            cache_idx   <= bus.addr[31:2];
            cache_data  <= bus.wdata;
         end else if (hit) begin
            cache_data  <= lane_merge(cache_data, bus.wdata[15:0], bus.addr[1:0], bus.size);
         end
      end else if (state == READ) begin
         cache_valid <= 1'b1;
         cache_idx   <= mem_addr_reg[29:0];
         cache_data  <= we_reg ? lane_merge(bus.mem_datar, wdata_reg, off_reg, size_reg)
                               : bus.mem_datar;
      end
   end
`else
   assign hit      = 1'b0;
   assign hit_word = '0;
`endif

   // State register; reset aborts any access in flight
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state <= IDLE;
      end else begin
         state <= state_next;
      end
   end

   // Next state and per-state strobes; memory strobes decode straight from state
   always_comb begin
      state_next  = state;
      bus.busy    = 1'b0;
      bus.done    = 1'b0;
      bus.err     = 1'b0;
      bus.mem_ren = 1'b0;
      bus.mem_wen = 1'b0;
      case (state)
         IDLE: begin
            if (bus.req) begin
               if (req_err) begin
                  state_next = DONE;
               end else if (bus.we) begin
                  state_next = (bus.size == SZ_WORD || hit) ? WRITE : READ;
               end else begin
                  state_next = hit ? DONE : READ;
               end
            end
         end
         READ: begin
            bus.busy    = 1'b1;
            bus.mem_ren = 1'b1;
            state_next  = we_reg ? WRITE : DONE;
         end
         WRITE: begin
            bus.busy    = 1'b1;
            bus.mem_wen = 1'b1;
            state_next  = DONE;
         end
         DONE: begin
            bus.done   = 1'b1;
            bus.err    = err_reg;
            state_next = IDLE;
         end
         default: state_next = IDLE;
      endcase
   end

   // Request capture, memory address/data staging and load result
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         we_reg        <= 1'b0;
         size_reg      <= SZ_BYTE;
         sign_reg      <= 1'b0;
         off_reg       <= 2'b00;
         wdata_reg     <= '0;
         err_reg       <= 1'b0;
         rdata_reg     <= '0;
         mem_addr_reg  <= '0;
         mem_dataw_reg <= '0;
      end else begin
         if (accept) begin
            we_reg    <= bus.we;
            size_reg  <= bus.size;
            sign_reg  <= bus.sign_ext;
            off_reg   <= bus.addr[1:0];
            wdata_reg <= bus.wdata[15:0];
            err_reg   <= req_err;
            // Rejected requests leave the memory port and rdata untouched
            if (!req_err) begin
               mem_addr_reg <= {2'b00, bus.addr[31:2]};
               if (bus.we && bus.size == SZ_WORD) begin
                  mem_dataw_reg <= bus.wdata;
               end else if (bus.we && hit) begin
                  mem_dataw_reg <= lane_merge(hit_word, bus.wdata[15:0], bus.addr[1:0], bus.size);
               end else if (!bus.we && hit) begin
                  rdata_reg <= lane_extract(hit_word, bus.addr[1:0], bus.size, bus.sign_ext);
               end
            end
         end
         if (state == READ) begin
            if (we_reg) begin
               mem_dataw_reg <= lane_merge(bus.mem_datar, wdata_reg, off_reg, size_reg);
            end else begin
               rdata_reg <= lane_extract(bus.mem_datar, off_reg, size_reg, sign_reg);
            end
         end
      end
   end

   assign bus.rdata     = rdata_reg;
   assign bus.mem_addr  = mem_addr_reg;
   assign bus.mem_dataw = mem_dataw_reg;

endmodule

// File: tb/tb_load_store_unit.sv
// Directed bench for load_store_unit: a word-array memory model, a
// transaction-level reference model and one per-cycle compare process.
module tb_load_store_unit;
   localparam int MEM_WORDS = 256;

   logic clk = 1'b0;
   logic rst;
   logic mem_init;
   always #5 clk = ~clk;

   load_store_unit_if lsu_bus();

   load_store_unit #(.MEM_WORDS(MEM_WORDS)) dut (
      .clk (clk),
      .rst (rst),
      .bus (lsu_bus)
   );

   // Data memory: combinational read, write on the clock edge
   logic [31:0] mem [0:MEM_WORDS-1];
   assign lsu_bus.mem_datar = mem[lsu_bus.mem_addr[7:0]];

   function automatic logic [31:0] seed(input int i);
      if (i == 16) return 32'd123;
      return {8'(i) ^ 8'hC3, 8'(i * 7), 8'h80 | 8'(i), 8'(i)};
   endfunction

   always @(posedge clk) begin
      if (mem_init) begin
         for (int i = 0; i < MEM_WORDS; i++) mem[i] <= seed(i);
      end else if (lsu_bus.mem_wen) begin
         mem[lsu_bus.mem_addr[7:0]] <= lsu_bus.mem_dataw;
      end
   end

   int errors = 0;
   int checks = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   // Reference model state
   logic [31:0] ref_mem [0:MEM_WORDS-1];
   logic [31:0] model_rdata;
`ifdef LSU_WORD_CACHE_EN
   bit c_valid;
   int c_idx;
`endif

   // Expectations for the transaction in flight (written by the driver only)
   logic        exp_we;
   logic [31:0] exp_addr;
   logic        exp_err;
   logic [31:0] exp_rdata;
   logic [31:0] exp_idx;
   logic [31:0] exp_dataw;
   int          exp_lat, exp_ren, exp_wen;
   bit          active = 0;
   int          issue_seq = 0;
   int          done_base;

   // Monitor-owned observations
   int          seen_seq = 0;
   int          cyc, ren_cnt, wen_cnt;
   int          wen_total = 0;
   int          done_seen = 0;
   int          last_lat = 0;
   logic [31:0] last_dataw = '0;

   // Transaction-level model: error rules, latency, strobe counts, data
   task automatic model(input logic w, input logic [1:0] sz, input logic sx,
                        input logic [31:0] a, input logic [31:0] wd);
      int idx, off;
      logic [7:0]  by [4];
      logic [31:0] word;
      bit hit;
      idx = int'(a[31:2]);
      off = int'(a[1:0]);
      hit = 0;
`ifdef LSU_WORD_CACHE_EN
      hit = c_valid && (c_idx == idx);
`endif
      exp_we = w; exp_addr = a;
      exp_ren = 0; exp_wen = 0; exp_idx = 32'(idx); exp_dataw = '0;
      exp_err = (sz == 2'd3) || (sz == 2'd1 && off % 2 != 0) ||
                (sz == 2'd2 && off != 0) || (idx >= MEM_WORDS);
      if (exp_err) begin
         exp_lat = 1;
      end else begin
         word = ref_mem[idx];
         for (int k = 0; k < 4; k++) by[k] = word[8*k +: 8];
         if (!w) begin
            if (sz == 2'd2) begin
               model_rdata = word;
            end else if (sz == 2'd1) begin
               model_rdata = 32'(by[off]) + 32'(by[off+1]) * 256;
               if (sx && model_rdata >= 32'h8000) model_rdata += 32'hFFFF0000;
            end else begin
               model_rdata = 32'(by[off]);
               if (sx && model_rdata >= 32'h80) model_rdata += 32'hFFFFFF00;
            end
            exp_ren = hit ? 0 : 1;
            exp_lat = hit ? 1 : 2;
         end else begin
            if (sz == 2'd2) begin
               word = wd;
               exp_lat = 2;
            end else begin
               by[off] = wd[7:0];
               if (sz == 2'd1) by[off+1] = wd[15:8];
               word = {by[3], by[2], by[1], by[0]};
               exp_ren = hit ? 0 : 1;
               exp_lat = hit ? 2 : 3;
            end
            ref_mem[idx] = word;
            exp_wen = 1;
            exp_dataw = word;
         end
`ifdef LSU_WORD_CACHE_EN
         c_valid = 1;
         c_idx = idx;
`endif
      end
      exp_rdata = model_rdata;
   endtask

   // Per-cycle compare process, sampling 1 time unit after the active edge
   always begin
      @(posedge clk);
      #1;
      if (lsu_bus.mem_wen) wen_total++;
      if (active) begin
         if (issue_seq != seen_seq) begin
            seen_seq = issue_seq;
            cyc = 0; ren_cnt = 0; wen_cnt = 0;
         end
         cyc++;
         chk("wen_ren_exclusive", 32'(lsu_bus.mem_wen & lsu_bus.mem_ren), 32'd0);
         chk("busy", 32'(lsu_bus.busy), 32'(cyc < exp_lat));
         chk("done", 32'(lsu_bus.done), 32'(cyc == exp_lat));
         if (lsu_bus.mem_ren) begin
            ren_cnt++;
            chk("ren_addr", lsu_bus.mem_addr, exp_idx);
         end
         if (lsu_bus.mem_wen) begin
            wen_cnt++;
            last_dataw = lsu_bus.mem_dataw;
            chk("wen_addr", lsu_bus.mem_addr, exp_idx);
            chk("wen_data", lsu_bus.mem_dataw, exp_dataw);
         end
         if (lsu_bus.done) begin
            done_seen++;
            last_lat = cyc;
            chk("err", 32'(lsu_bus.err), 32'(exp_err));
            chk("rdata", lsu_bus.rdata, exp_rdata);
            chk("ren_pulses", 32'(ren_cnt), 32'(exp_ren));
            chk("wen_pulses", 32'(wen_cnt), 32'(exp_wen));
            $display("txn %0d: we=%0b addr=%h err=%0b rdata=%h lat=%0d ren=%0d wen=%0d",
                     issue_seq, exp_we, exp_addr, lsu_bus.err, lsu_bus.rdata, cyc, ren_cnt, wen_cnt);
         end
      end
   end

   task automatic issue(input logic w, input logic [1:0] sz, input logic sx,
                        input logic [31:0] a, input logic [31:0] wd);
      @(negedge clk);
      model(w, sz, sx, a, wd);
      done_base = done_seen;
      lsu_bus.req = 1'b1; lsu_bus.we = w; lsu_bus.size = sz;
      lsu_bus.sign_ext = sx; lsu_bus.addr = a; lsu_bus.wdata = wd;
      issue_seq++;
      active = 1;
      @(negedge clk);
      // Scramble inputs after capture; the unit must not look at them again
      lsu_bus.req = 1'b0; lsu_bus.we = ~w; lsu_bus.size = ~sz;
      lsu_bus.sign_ext = ~sx; lsu_bus.addr = ~a; lsu_bus.wdata = ~wd;
   endtask

   task automatic wait_done();
      int t;
      t = 0;
      while (done_seen == done_base && t < 12) begin
         @(posedge clk); #2;
         t++;
      end
      repeat (2) begin @(posedge clk); #2; end
      chk("done_count", 32'(done_seen - done_base), 32'd1);
   endtask

   task automatic op(input logic w, input logic [1:0] sz, input logic sx,
                     input logic [31:0] a, input logic [31:0] wd);
      issue(w, sz, sx, a, wd);
      wait_done();
   endtask

   initial begin
      #300000;
      $display("FAIL watchdog: simulation did not finish, errors=%0d", errors);
      $fatal(1, "watchdog");
   end

   initial begin
      int wen_base, mism;
      rst = 1'b1; mem_init = 1'b1;
      lsu_bus.req = 1'b0; lsu_bus.we = 1'b0; lsu_bus.size = 2'b00;
      lsu_bus.sign_ext = 1'b0; lsu_bus.addr = '0; lsu_bus.wdata = '0;
      for (int i = 0; i < MEM_WORDS; i++) ref_mem[i] = seed(i);
      model_rdata = '0;
`ifdef LSU_WORD_CACHE_EN
      c_valid = 0; c_idx = 0;
`endif
      repeat (3) @(negedge clk);
      mem_init = 1'b0;
      chk("rst_busy", 32'(lsu_bus.busy), 32'd0);
      chk("rst_done", 32'(lsu_bus.done), 32'd0);
      chk("rst_err", 32'(lsu_bus.err), 32'd0);
      chk("rst_rdata", lsu_bus.rdata, 32'd0);
      chk("rst_wen", 32'(lsu_bus.mem_wen), 32'd0);
      chk("rst_ren", 32'(lsu_bus.mem_ren), 32'd0);
      chk("rst_mem_addr", lsu_bus.mem_addr, 32'd0);
      chk("rst_mem_dataw", lsu_bus.mem_dataw, 32'd0);
      @(negedge clk);
      rst = 1'b0;

      op(1'b0, 2'd2, 1'b0, 32'h40, 32'h0);
      chk("lit_load_word16", lsu_bus.rdata, 32'h0000007B);
      op(1'b1, 2'd0, 1'b0, 32'h41, 32'h000000AA);
      chk("lit_rmw_dataw", last_dataw, 32'h0000AA7B);
      op(1'b0, 2'd0, 1'b1, 32'h41, 32'h0);
      chk("lit_byte_signed", lsu_bus.rdata, 32'hFFFFFFAA);
      op(1'b0, 2'd0, 1'b0, 32'h41, 32'h0);
      chk("lit_byte_unsigned", lsu_bus.rdata, 32'h000000AA);

      // Reset in the middle of a sub-word store's READ cycle
      active = 0;
      wen_base = wen_total;
      @(negedge clk);
      lsu_bus.req = 1'b1; lsu_bus.we = 1'b1; lsu_bus.size = 2'd0;
      lsu_bus.sign_ext = 1'b0; lsu_bus.addr = 32'h80; lsu_bus.wdata = 32'h11;
      @(negedge clk);
      lsu_bus.req = 1'b0;
      chk("abort_busy_before", 32'(lsu_bus.busy), 32'd1);
      #1 rst = 1'b1;
      #1;
      chk("abort_busy", 32'(lsu_bus.busy), 32'd0);
      chk("abort_done", 32'(lsu_bus.done), 32'd0);
      chk("abort_ren", 32'(lsu_bus.mem_ren), 32'd0);
      chk("abort_wen", 32'(lsu_bus.mem_wen), 32'd0);
      @(negedge clk);
      rst = 1'b0;
      model_rdata = '0;
`ifdef LSU_WORD_CACHE_EN
      c_valid = 0;
`endif
      repeat (3) @(negedge clk);
      chk("abort_no_wen", 32'(wen_total - wen_base), 32'd0);
      chk("abort_word32", mem[32], ref_mem[32]);
      chk("lit_word16", mem[16], 32'h0000AA7B);
      chk("abort_rdata_cleared", lsu_bus.rdata, 32'd0);

      op(1'b1, 2'd1, 1'b0, 32'h43, 32'h1234);     // misaligned halfword
      op(1'b0, 2'd2, 1'b0, 32'h400, 32'h0);       // index 256 out of range
      op(1'b0, 2'd3, 1'b0, 32'h44, 32'h0);        // illegal size
      op(1'b0, 2'd2, 1'b0, 32'h42, 32'h0);        // misaligned word
      op(1'b1, 2'd1, 1'b0, 32'h46, 32'h0000BEEF);
      op(1'b0, 2'd1, 1'b1, 32'h46, 32'h0);
      op(1'b0, 2'd2, 1'b0, 32'h44, 32'h0);
      chk("lit_word17", lsu_bus.rdata, 32'hBEEF9111);
      op(1'b0, 2'd0, 1'b1, 32'h47, 32'h0);
      op(1'b1, 2'd0, 1'b0, 32'h3FF, 32'h0000005C);
      op(1'b0, 2'd2, 1'b0, 32'h3FC, 32'h0);
      op(1'b0, 2'd1, 1'b0, 32'h22, 32'h0);
      op(1'b0, 2'd0, 1'b1, 32'h31, 32'h0);

      // Requests while busy and during DONE are dropped
      @(negedge clk);
      model(1'b0, 2'd2, 1'b0, 32'h50, 32'h0);
      done_base = done_seen;
      lsu_bus.req = 1'b1; lsu_bus.we = 1'b0; lsu_bus.size = 2'd2;
      lsu_bus.sign_ext = 1'b0; lsu_bus.addr = 32'h50;
      issue_seq++;
      active = 1;
      @(negedge clk);
      lsu_bus.addr = 32'h60;
      @(negedge clk);
      lsu_bus.addr = 32'h70;
      @(negedge clk);
      lsu_bus.req = 1'b0;
      wait_done();
      chk("hold_mem_addr", lsu_bus.mem_addr, 32'd20);

      // Back-to-back loads of one word, then store-word followed by load
      op(1'b0, 2'd2, 1'b0, 32'h40, 32'h0);
      op(1'b0, 2'd2, 1'b0, 32'h40, 32'h0);
`ifdef LSU_WORD_CACHE_EN
      chk("lit_repeat_latency", 32'(last_lat), 32'd1);
`else
      chk("lit_repeat_latency", 32'(last_lat), 32'd2);
`endif
      op(1'b1, 2'd2, 1'b0, 32'h40, 32'h12345678);
      op(1'b0, 2'd2, 1'b0, 32'h40, 32'h0);
      chk("lit_store_load", lsu_bus.rdata, 32'h12345678);

      mism = 0;
      for (int i = 0; i < MEM_WORDS; i++) if (mem[i] !== ref_mem[i]) mism++;
      chk("mem_image_mismatches", 32'(mism), 32'd0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
